// File: rtl/click_decoder_pkg.sv
// Shared definitions for the click decoder: FSM state encoding and
// default timing parameters.
package click_decoder_pkg;

  localparam int CNT_W = 16;

  localparam logic [CNT_W-1:0] DEF_LONG_CYCLES = 16'd1000;
  localparam logic [CNT_W-1:0] DEF_GAP_CYCLES  = 16'd300;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HELD      = 3'd1,
    LONG_HELD = 3'd2,
    WAIT2     = 3'd3,
    HELD2     = 3'd4
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating sample counter with clear, load-one and increment controls.
// The terminal flag looks one sample ahead: it is high when the next
// increment would land exactly on the selected terminal value, so the
// FSM can fire its pulse on that same edge.
module sat_counter
  import click_decoder_pkg::*;
#(
  parameter logic [CNT_W-1:0] TERM_A = DEF_LONG_CYCLES,
  parameter logic [CNT_W-1:0] TERM_B = DEF_GAP_CYCLES
) (
  input  logic clk,
  input  logic r,
  input  logic clr,
  input  logic start,
  input  logic inc,
  input  logic sel_b,
  output logic hit
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] term;

  // Count register: clear wins over load-one, which wins over increment;
  // the increment holds at all-ones so the count never wraps.
  always_ff @(posedge clk) begin
    if (!r) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Terminal selection and look-ahead compare.
  always_comb begin
    term = sel_b ? TERM_B : TERM_A;
    hit  = ((cnt + 1'b1) == term);
  end

endmodule

// File: rtl/click_decoder.sv
// Button click decoder: classifies debounced presses into short press,
// long press and double click, plus a pulse for every accepted press start.
// All outputs are registered single-cycle pulses; state is exposed for
// observation.
module click_decoder
  import click_decoder_pkg::*;
#(
  parameter logic [CNT_W-1:0] LONG_CYCLES = DEF_LONG_CYCLES,
  parameter logic [CNT_W-1:0] GAP_CYCLES  = DEF_GAP_CYCLES
) (
  input  logic   clk,
  input  logic   r,
  input  logic   clicked,
  output logic   press_pulse,
  output logic   short_press,
  output logic   long_press,
  output logic   double_click,
  output state_t state
);

  state_t state_d;
  logic   press_d, short_d, long_d, double_d;
  logic   cnt_clr, cnt_start, cnt_inc, sel_gap, cnt_hit;

  // One shared counter: held-time against LONG_CYCLES, gap time against
  // GAP_CYCLES.
  sat_counter #(
    .TERM_A (LONG_CYCLES),
    .TERM_B (GAP_CYCLES)
  ) u_cnt (
    .clk   (clk),
    .r     (r),
    .clr   (cnt_clr),
    .start (cnt_start),
    .inc   (cnt_inc),
    .sel_b (sel_gap),
    .hit   (cnt_hit)
  );

  // Next-state, counter control and pulse decode.
  always_comb begin
    state_d   = state;
    press_d   = 1'b0;
    short_d   = 1'b0;
    long_d    = 1'b0;
    double_d  = 1'b0;
    cnt_clr   = 1'b0;
    cnt_start = 1'b0;
    cnt_inc   = 1'b0;
    sel_gap   = 1'b0;
    case (state)
      IDLE: begin
        if (clicked) begin
          state_d   = HELD;
          cnt_start = 1'b1;
          press_d   = 1'b1;
        end
      end
      HELD: begin
        if (clicked) begin
          cnt_inc = 1'b1;
          if (cnt_hit) begin
            long_d  = 1'b1;
            state_d = LONG_HELD;
          end
        end else begin
          state_d   = WAIT2;
          cnt_start = 1'b1;
        end
      end
      LONG_HELD: begin
        if (!clicked) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end
      end
      WAIT2: begin
        sel_gap = 1'b1;
        if (clicked) begin
          double_d = 1'b1;
          press_d  = 1'b1;
          state_d  = HELD2;
          cnt_clr  = 1'b1;
        end else begin
          cnt_inc = 1'b1;
          if (cnt_hit) begin
            short_d = 1'b1;
            state_d = IDLE;
            cnt_clr = 1'b1;
          end
        end
      end
      HELD2: begin
        if (!clicked) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_clr = 1'b1;
      end
    endcase
  end

  // State and output pulse registers; reset discards any pending event.
  always_ff @(posedge clk) begin
    if (!r) begin
      state        <= IDLE;
      press_pulse  <= 1'b0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_click <= 1'b0;
    end else begin
      state        <= state_d;
      press_pulse  <= press_d;
      short_press  <= short_d;
      long_press   <= long_d;
      double_click <= double_d;
    end
  end

endmodule

// File: tb/tb_click_decoder.sv
// Directed and randomized test of click_decoder with LONG_CYCLES=8,
// GAP_CYCLES=5 against a run-length based reference model.
module tb_click_decoder;
  import click_decoder_pkg::*;

  localparam int L = 8;
  localparam int G = 5;

  logic   clk = 1'b0;
  logic   r = 1'b0;
  logic   clicked = 1'b0;
  logic   press_pulse, short_press, long_press, double_click;
  state_t state;

  int n_checks = 0;
  int n_fail   = 0;
  int n_steps  = 0;

  // Reference model: tracks the current high run, whether a short press is
  // waiting for a follow-up, and the length of the low gap after it.
  bit m_in_press, m_second, m_long_done, m_pending;
  int m_run, m_gap;
  bit e_pp, e_sp, e_lp, e_dc;

  click_decoder #(
    .LONG_CYCLES (16'(L)),
    .GAP_CYCLES  (16'(G))
  ) dut (
    .clk          (clk),
    .r            (r),
    .clicked      (clicked),
    .press_pulse  (press_pulse),
    .short_press  (short_press),
    .long_press   (long_press),
    .double_click (double_click),
    .state        (state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic model_reset();
    m_in_press = 0; m_second = 0; m_long_done = 0; m_pending = 0;
    m_run = 0; m_gap = 0;
    e_pp = 0; e_sp = 0; e_lp = 0; e_dc = 0;
  endtask

  task automatic model(input logic c, input logic rn);
    e_pp = 0; e_sp = 0; e_lp = 0; e_dc = 0;
    if (!rn) begin
      model_reset();
    end else if (c) begin
      if (!m_in_press) begin
        e_pp = 1;
        m_in_press = 1;
        m_run = 1;
        m_long_done = 0;
        m_second = m_pending;
        e_dc = m_pending;
        m_pending = 0;
      end else begin
        m_run++;
        if (!m_second && !m_long_done && m_run == L) begin
          e_lp = 1;
          m_long_done = 1;
        end
      end
    end else begin
      if (m_in_press) begin
        m_in_press = 0;
        if (!m_second && !m_long_done) begin
          m_pending = 1;
          m_gap = 1;
        end
      end else if (m_pending) begin
        m_gap++;
        if (m_gap == G) begin
          e_sp = 1;
          m_pending = 0;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b step=%0d", tag, obs, exp, n_steps);
    end
  endtask

  // Drive one sample, advance one edge, then compare away from the edge.
  task automatic step(input logic c, input logic rn);
    clicked = c;
    r = rn;
    @(posedge clk);
    model(c, rn);
    n_steps++;
    @(negedge clk);
    check("press_pulse", press_pulse, e_pp);
    check("short_press", short_press, e_sp);
    check("long_press", long_press, e_lp);
    check("double_click", double_click, e_dc);
    check("state_idle", state == IDLE, !m_in_press && !m_pending);
    check("one_hot_event", (int'(short_press) + int'(long_press) + int'(double_click)) <= 1, 1'b1);
  endtask

  task automatic run(input logic c, input int n);
    for (int i = 0; i < n; i++) step(c, 1'b1);
  endtask

  initial begin
    model_reset();
    // Reset state
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);

    // Short press: high 3, low until gap closes
    run(1'b0, 2);
    run(1'b1, 3);
    run(1'b0, 8);

    // Long press: high 12, then release
    run(1'b1, 12);
    run(1'b0, 4);

    // Double click: 2 high, 2 low, 2 high, low
    run(1'b1, 2);
    run(1'b0, 2);
    run(1'b1, 2);
    run(1'b0, 8);

    // Gap closes exactly, then a new press
    run(1'b1, 2);
    run(1'b0, 5);
    run(1'b1, 1);
    run(1'b0, 8);

    // Reset mid-press at cnt=5, then release
    run(1'b1, 5);
    step(1'b1, 1'b0);
    run(1'b0, 6);

    // Reset mid-gap
    run(1'b1, 2);
    run(1'b0, 3);
    step(1'b0, 1'b0);
    run(1'b0, 6);

    // Reset coincident with rising clicked, held through release
    step(1'b1, 1'b0);
    run(1'b1, 3);
    run(1'b0, 8);

    // Long-held second press never yields long_press
    run(1'b1, 1);
    run(1'b0, 1);
    run(1'b1, 15);
    run(1'b0, 8);

    // Randomized runs with occasional resets
    for (int k = 0; k < 400; k++) begin
      int hi, lo;
      hi = $urandom_range(1, 12);
      lo = $urandom_range(1, 8);
      for (int i = 0; i < hi; i++) step(1'b1, ($urandom_range(0, 59) != 0));
      for (int i = 0; i < lo; i++) step(1'b0, ($urandom_range(0, 59) != 0));
    end
    run(1'b0, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
